// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with optional two's-complement mode.
//
// One quotient bit is produced per clock. Signed operations are handled by dividing
// magnitudes and fixing up the signs in a final cycle. A zero divisor skips the
// iteration entirely and reports all-ones quotient, the untouched dividend as the
// remainder, and div_by_zero=1.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        request a division (sampled only while busy=0)
//   signed_op    1 = signed division (ignored when SIGNED_EN=0), sampled with start
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         operation in progress; start ignored while high
//   done         one-cycle pulse, results valid
//   quotient     quotient, held until the next done
//   remainder    remainder, held until the next done
//   div_by_zero  divisor was zero for the last completed operation
module seq_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;    // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] denom_q, denom_d;  // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             sop;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign sop   = (SIGNED_EN != 0) ? signed_op : 1'b0;
  assign a_neg = sop & dividend[WIDTH-1];
  assign b_neg = sop & divisor[WIDTH-1];

  // The full WIDTH+1-bit shifted remainder is kept so that large unsigned divisors
  // (MSB set) cannot lose the top partial-remainder bit.
  assign shifted = {work_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, denom_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (divisor == '0) ? StFix : StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    work_d      = work_q;
    q_d         = q_q;
    denom_d     = denom_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            // Fix-up leaves these untouched: all-ones quotient, raw dividend remainder.
            work_d  = dividend;
            q_d     = '1;
            denom_d = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            zero_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            work_d  = '0;
            q_d     = a_neg ? -dividend : dividend;
            denom_d = b_neg ? -divisor : divisor;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            zero_d  = 1'b0;
            cnt_d   = CntW'(WIDTH - 1);
          end
        end
      end
      StRun: begin
        if (!trial[WIDTH]) begin
          work_d = trial[WIDTH-1:0];
          q_d    = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          work_d = shifted[WIDTH-1:0];
          q_d    = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        quotient_d  = q_neg_q ? -q_q : q_q;
        remainder_d = r_neg_q ? -work_q : work_q;
        dbz_d       = zero_q;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      work_q      <= '0;
      q_q         <= '0;
      denom_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      q_q         <= q_d;
      denom_q     <= denom_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32, SIGNED_EN=1).
// Stimulus pushes expected results; a monitor pops and checks on every done pulse.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_quotient"}, 64'(quotient), 64'(e.q));
        chk({e.name, "_remainder"}, 64'(remainder), 64'(e.r));
        chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.z));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Wait for an idle divider, present one operation and record its expected result.
  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sop,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input string nm);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, "_idle_timeout"}, 64'(busy), 64'(0));
    dividend  = dd;
    divisor   = dv;
    signed_op = sop;
    start     = 1'b1;
    e.q = eq; e.r = er; e.z = ez; e.name = nm;
    e.due = cyc + 1 + (ez ? 1 : int'(W) + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int   n;
    exp_t e;
    reset     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_quotient", 64'(quotient), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b1;

    // Basic unsigned, with busy duration
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100_7");
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(33));

    // Sign handling
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, "s_7_m2");
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, "u_big_2");
    issue(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, 1'b0, "s_m8_m3");
    issue(32'hFFFF_FFFA, 32'd3, 1'b1, 32'hFFFF_FFFE, 32'd0, 1'b0, "s_m6_3");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 1'b0, "u_max_maxm1");
    issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, "u_5_9");

    // Divide by zero, then a normal op clears the flag
    issue(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "u_dbz");
    issue(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, "s_dbz");
    issue(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, "u_10_3");

    // Signed overflow
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "s_ovf");

    // Start pulses while busy are ignored
    issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, "u_50_6_ign");
    repeat (4) @(negedge clk);
    dividend = 32'd999; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    dividend = 32'hFFFF_0000; divisor = 32'd0; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back: start held high through done
    @(negedge clk);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    dividend = 32'd77; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
    e.q = 32'd15; e.r = 32'd2; e.z = 1'b0; e.name = "b2b_first"; e.due = cyc + 1 + 33;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("b2b_done_seen", 64'(done), 64'(1));
    dividend = 32'd64; divisor = 32'd8;
    e.q = 32'd8; e.r = 32'd0; e.z = 1'b0; e.name = "b2b_second"; e.due = cyc + 1 + 33;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an operation
    issue(32'd12345, 32'd11, 1'b0, 32'd1122, 32'd3, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_quotient", 64'(quotient), 64'(0));
    chk("mid_rst_remainder", 64'(remainder), 64'(0));
    chk("mid_rst_dbz", 64'(div_by_zero), 64'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, "u_1000_10");

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
